// File: rtl/dfr_pkg.sv
// Shared state encoding and default sizing for the delay-feedback reservoir node sequencer.
package dfr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DRIVE  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_STORE  = 3'd5,
    ST_FINISH = 3'd6
  } dfr_state_e;

  localparam int DFR_NUM_NODES_DEF = 16;
  localparam int DFR_DATA_W_DEF    = 16;
  localparam int DFR_TIMEOUT_DEF   = 1024;
  localparam int DFR_ADDR_W        = 8;
  localparam int DFR_SETTLE_W      = 16;

  // The shared timer must hold both a full settle value and the timeout reload.
  function automatic int dfr_timer_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w > DFR_SETTLE_W) ? w : DFR_SETTLE_W;
  endfunction

endpackage

// File: rtl/dfr_cycle_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module dfr_cycle_timer
  import dfr_pkg::*;
#(
  parameter int WIDTH = DFR_SETTLE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/dfr_node_sequencer.sv
// Steps through the virtual reservoir nodes: fetch mask, drive DAC, settle, sample ADC, store.
module dfr_node_sequencer
  import dfr_pkg::*;
#(
  parameter int NUM_NODES      = DFR_NUM_NODES_DEF,
  parameter int DATA_W         = DFR_DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = DFR_TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [15:0]           settle_cycles,
  output logic [7:0]            mask_addr,
  input  logic [DATA_W-1:0]     mask_data,
  output logic [DATA_W-1:0]     dac_data,
  output logic                  dac_load,
  output logic                  adc_req,
  input  logic                  adc_ack,
  input  logic [DATA_W-1:0]     adc_data,
  output logic                  node_wr_en,
  output logic [7:0]            node_wr_addr,
  output logic [DATA_W-1:0]     node_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err
);

  localparam int         TMR_W    = dfr_timer_width(TIMEOUT_CYCLES);
  localparam logic [7:0] LAST_IDX = 8'(NUM_NODES - 1);

  dfr_state_e        state_q, state_d;
  logic [7:0]        idx_q;
  logic [15:0]       settle_q;
  logic [DATA_W-1:0] sample_q;
  logic [DATA_W-1:0] dac_data_q;
  logic              timeout_err_q;

  logic              tmr_load;
  logic              tmr_en;
  logic [TMR_W-1:0]  tmr_load_val;
  logic              tmr_expired;
  logic              capture;
  logic              timeout_hit;
  logic              sweep_accept;

  assign sweep_accept = (state_q == ST_IDLE) && start && !abort;

  dfr_cycle_timer #(
    .WIDTH(TMR_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (tmr_load),
    .enable    (tmr_en),
    .load_value(tmr_load_val),
    .expired   (tmr_expired)
  );

  always_comb begin
    state_d      = state_q;
    tmr_load     = 1'b0;
    tmr_en       = 1'b0;
    tmr_load_val = '0;
    capture      = 1'b0;
    timeout_hit  = 1'b0;
    if ((state_q != ST_IDLE) && abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sweep_accept) state_d = ST_FETCH;
        end
        ST_FETCH:  state_d = ST_DRIVE;
        ST_DRIVE: begin
          state_d      = ST_SETTLE;
          tmr_load     = 1'b1;
          tmr_load_val = TMR_W'(settle_q);
        end
        ST_SETTLE: begin
          tmr_en = 1'b1;
          // Reload for the ADC wait so SAMPLE lasts at most TIMEOUT_CYCLES cycles.
          if (tmr_expired) begin
            state_d      = ST_SAMPLE;
            tmr_load     = 1'b1;
            tmr_load_val = TMR_W'(TIMEOUT_CYCLES - 1);
          end
        end
        ST_SAMPLE: begin
          tmr_en = 1'b1;
          if (adc_ack) begin
            capture = 1'b1;
            state_d = ST_STORE;
          end else if (tmr_expired) begin
            timeout_hit = 1'b1;
            state_d     = ST_IDLE;
          end
        end
        ST_STORE:  state_d = (idx_q == LAST_IDX) ? ST_FINISH : ST_FETCH;
        ST_FINISH: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      settle_q      <= '0;
      sample_q      <= '0;
      dac_data_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (sweep_accept) begin
        idx_q         <= '0;
        settle_q      <= settle_cycles;
        timeout_err_q <= 1'b0;
      end
      if ((state_q == ST_DRIVE) && !abort) dac_data_q <= mask_data;
      if (capture) sample_q <= adc_data;
      if ((state_q == ST_STORE) && (state_d == ST_FETCH)) idx_q <= idx_q + 8'd1;
      if (timeout_hit) timeout_err_q <= 1'b1;
    end
  end

  // Strobes are gated so an abort or reset in the same cycle suppresses them.
  assign mask_addr    = (state_q == ST_FETCH) ? idx_q : 8'd0;
  assign dac_data     = dac_data_q;
  assign dac_load     = (state_q == ST_DRIVE) && !abort && !rst;
  assign adc_req      = (state_q == ST_SAMPLE);
  assign node_wr_en   = (state_q == ST_STORE) && !abort && !rst;
  assign node_wr_addr = idx_q;
  assign node_wr_data = sample_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_FINISH) && !abort && !rst;
  assign timeout_err  = timeout_err_q;

endmodule
